// File: rtl/lcd_avalon_slave.sv
//==============================================================================
// Module   : lcd_avalon_slave
// Brief    : Avalon-MM slave generating timed HD44780 write cycles with
//            status and last-data readback.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_avalon_slave #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 12,
  parameter int HOLD_CYCLES    = 2,
  parameter int CMD_CYCLES     = 2000,
  parameter int CLEAR_CYCLES   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic       waitrequest,
  output logic [7:0] readdata,
  output logic [1:0] response,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon
);

  // Counters are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [31:0] c_PWR_LOAD   = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] c_SETUP_LOAD = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] c_PULSE_LOAD = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] c_HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] c_CMD_LOAD   = 32'(CMD_CYCLES - 1);
  localparam logic [31:0] c_CLEAR_LOAD = 32'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_SETUP   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLD    = 3'd4,
    S_EXEC    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_rs;
  logic [7:0]  r_data;
  logic [6:0]  r_ddram_addr;
  logic [7:0]  r_last_data;
  logic        r_power;

  logic w_req_wr;
  logic w_req_rd;
  logic w_req_err;
  logic w_cnt_zero;
  logic w_clear_home;

  assign w_req_wr   = chipselect && write && !read && byteenable;
  assign w_req_rd   = chipselect && read && !write;
  assign w_req_err  = chipselect && write && (read || !byteenable);
  assign w_cnt_zero = (r_cnt == 32'd0);
  // Clear (0x01) and Home (0x02/0x03) are the slow commands.
  assign w_clear_home = !r_rs && (r_data[7:2] == 6'd0) && (r_data[1:0] != 2'd0);

  assign waitrequest = (r_state != S_DONE);
  assign lcd_rw      = 1'b0;
  assign lcd_on      = r_power;
  assign lcd_blon    = r_power;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_POWERUP;
      r_cnt        <= c_PWR_LOAD;
      r_rs         <= 1'b0;
      r_data       <= 8'd0;
      r_ddram_addr <= 7'd0;
      r_last_data  <= 8'd0;
      r_power      <= 1'b0;
      readdata     <= 8'd0;
      response     <= 2'b00;
      lcd_data     <= 8'd0;
      lcd_rs       <= 1'b0;
      lcd_en       <= 1'b0;
    end else begin
      r_power <= 1'b1;
      case (r_state)
        S_POWERUP: begin
          if (w_cnt_zero) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt - 32'd1;
        end
        S_IDLE: begin
          if (w_req_wr) begin
            r_rs     <= address;
            r_data   <= writedata;
            lcd_rs   <= address;
            lcd_data <= writedata;
            response <= 2'b00;
            r_cnt    <= c_SETUP_LOAD;
            r_state  <= S_SETUP;
          end else if (w_req_rd) begin
            readdata <= address ? r_last_data : {1'b0, r_ddram_addr};
            response <= 2'b00;
            r_state  <= S_DONE;
          end else if (w_req_err) begin
            response <= 2'b10;
            r_state  <= S_DONE;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            lcd_en  <= 1'b1;
            r_cnt   <= c_PULSE_LOAD;
            r_state <= S_PULSE;
          end else r_cnt <= r_cnt - 32'd1;
        end
        S_PULSE: begin
          if (w_cnt_zero) begin
            lcd_en  <= 1'b0;
            r_cnt   <= c_HOLD_LOAD;
            r_state <= S_HOLD;
          end else r_cnt <= r_cnt - 32'd1;
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_cnt   <= w_clear_home ? c_CLEAR_LOAD : c_CMD_LOAD;
            r_state <= S_EXEC;
            if (r_rs) begin
              r_ddram_addr <= r_ddram_addr + 7'd1;
              r_last_data  <= r_data;
            end else if (r_data[7]) begin
              r_ddram_addr <= r_data[6:0];
            end else if (w_clear_home) begin
              r_ddram_addr <= 7'd0;
            end
          end else r_cnt <= r_cnt - 32'd1;
        end
        S_EXEC: begin
          if (w_cnt_zero) r_state <= S_DONE;
          else            r_cnt   <= r_cnt - 32'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
